// File: rtl/trng_sample_sequencer_if.sv
// Control, latch-network and byte-stream signals of the TRNG sample sequencer.
// master = controller/consumer side (testbench or SoC glue), slave = sequencer.
interface trng_sample_sequencer_if;
    logic       start;
    logic       stop;
    logic       lat_rst_n;
    logic       lat_enable;
    logic       lat_bit;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic       rnd_ready;
    logic       overrun;
    logic       health_fail;
    logic       busy;

    modport master (
        output start, stop, lat_bit, rnd_ready,
        input  lat_rst_n, lat_enable, rnd_data, rnd_valid, overrun, health_fail, busy
    );

    modport slave (
        input  start, stop, lat_bit, rnd_ready,
        output lat_rst_n, lat_enable, rnd_data, rnd_valid, overrun, health_fail, busy
    );
endinterface

// File: rtl/trng_sample_sequencer.sv
// Warms up the SR-latch network, packs one bit per SAMPLE_DIV cycles into bytes (first bit in MSB) and runs a repetition test.
// First byte WARMUP_CYCLES+8*SAMPLE_DIV+1 cycles after start; one-entry output buffer, a full buffer without rnd_ready drops the byte and sets overrun.
module trng_sample_sequencer #(
    parameter int WARMUP_CYCLES = 16,
    parameter int SAMPLE_DIV    = 2,
    parameter int REP_LIMIT     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    trng_sample_sequencer_if.slave      bus
);

    localparam int WCW = $clog2(WARMUP_CYCLES + 1);
    localparam int DCW = $clog2(SAMPLE_DIV + 1);
    localparam int RCW = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_run;
    logic [WCW-1:0]   r_warm_cnt;
    logic [DCW-1:0]   r_div_cnt;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [RCW-1:0]   r_rep_cnt;
    logic             r_prev_bit;
    logic [7:0]       r_rnd_data;
    logic             r_rnd_valid;
    logic             r_overrun;
    logic             r_health_fail;

    logic             w_sample;
    logic [RCW-1:0]   w_rep_nxt;
    logic             w_byte_done;
    logic [7:0]       w_byte;

    // r_rep_cnt == 0 marks "no sample yet since entering SAMPLE".
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_rep_nxt   = RCW'(1);
        if (r_rep_cnt != '0 && bus.lat_bit == r_prev_bit) begin
            w_rep_nxt = r_rep_cnt + RCW'(1);
        end
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.stop) w_state_nxt = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_warm_cnt == WCW'(WARMUP_CYCLES - 1)) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_sample = (r_div_cnt == DCW'(SAMPLE_DIV - 1));
                    if (w_sample && w_rep_nxt == RCW'(REP_LIMIT)) w_state_nxt = ST_FAIL;
                end
            end
            default: w_state_nxt = ST_FAIL;
        endcase
    end

    assign w_byte      = {r_shift[6:0], bus.lat_bit};
    assign w_byte_done = w_sample && (r_bit_cnt == 3'd7) && (w_state_nxt == ST_SAMPLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_run         <= 1'b0;
            r_warm_cnt    <= '0;
            r_div_cnt     <= '0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_rep_cnt     <= '0;
            r_prev_bit    <= 1'b0;
            r_rnd_data    <= '0;
            r_rnd_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_health_fail <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= (w_state_nxt == ST_WARMUP) || (w_state_nxt == ST_SAMPLE);

            if (r_state == ST_WARMUP && w_state_nxt == ST_WARMUP) begin
                r_warm_cnt <= r_warm_cnt + WCW'(1);
            end else begin
                r_warm_cnt <= '0;
            end

            // Entering or leaving SAMPLE wipes the partial byte and the repetition history.
            if (r_state != ST_SAMPLE || w_state_nxt != ST_SAMPLE) begin
                r_div_cnt  <= '0;
                r_shift    <= '0;
                r_bit_cnt  <= '0;
                r_rep_cnt  <= '0;
                r_prev_bit <= 1'b0;
            end else begin
                r_div_cnt <= w_sample ? '0 : r_div_cnt + DCW'(1);
                if (w_sample) begin
                    r_shift    <= w_byte;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    r_rep_cnt  <= w_rep_nxt;
                    r_prev_bit <= bus.lat_bit;
                end
            end

            if (w_state_nxt == ST_FAIL) begin
                r_rnd_valid   <= 1'b0;
                r_health_fail <= 1'b1;
            end else if (w_byte_done) begin
                if (!r_rnd_valid || bus.rnd_ready) begin
                    r_rnd_data  <= w_byte;
                    r_rnd_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rnd_valid && bus.rnd_ready) begin
                r_rnd_valid <= 1'b0;
            end
        end
    end

    assign bus.lat_rst_n   = r_run;
    assign bus.lat_enable  = r_run;
    assign bus.busy        = r_run;
    assign bus.rnd_data    = r_rnd_data;
    assign bus.rnd_valid   = r_rnd_valid;
    assign bus.overrun     = r_overrun;
    assign bus.health_fail = r_health_fail;

endmodule
